// File: rtl/jtopl_wrseq.sv
// rtl/jtopl_wrseq.sv - round-robin register-write sequencer driving the OPL CPU bus
module jtopl_wrseq #(
    parameter int ADDR_WAIT = 12,
    parameter int DATA_WAIT = 84
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       a_valid,
    input  logic [7:0] a_reg,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_reg,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       opl_addr,
    output logic [7:0] opl_din,
    output logic       opl_cs_n,
    output logic       opl_wr_n,
    output logic       busy,
    output logic       last_b
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_WR,
        ST_ADDR_WAIT,
        ST_DATA_WR,
        ST_DATA_WAIT
    } state_t;

    localparam logic [6:0] ADDR_CNT = 7'(ADDR_WAIT);
    localparam logic [6:0] DATA_CNT = 7'(DATA_WAIT);

    state_t     state, state_nx;
    logic [6:0] cnt, cnt_nx, cnt_inc;
    logic [7:0] reg_q, reg_nx, data_q, data_nx;
    logic       last_b_nx;
    logic       grant_a, grant_b;
    logic       strobe_nx, addr_nx;
    logic [7:0] din_nx;

    // Round robin: on contention the side not granted last wins.
    assign grant_a = a_valid && (!b_valid || last_b);
    assign grant_b = b_valid && (!a_valid || !last_b);
    assign a_ready = rst_n && (state == ST_IDLE) && grant_a;
    assign b_ready = rst_n && (state == ST_IDLE) && grant_b;
    assign busy    = (state != ST_IDLE);
    assign cnt_inc = cnt + 7'd1;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        reg_nx    = reg_q;
        data_nx   = data_q;
        last_b_nx = last_b;
        case (state)
            ST_IDLE: begin
                cnt_nx = 7'd0;
                if (a_ready) begin
                    reg_nx    = a_reg;
                    data_nx   = a_data;
                    last_b_nx = 1'b0;
                    state_nx  = ST_ADDR_WR;
                end else if (b_ready) begin
                    reg_nx    = b_reg;
                    data_nx   = b_data;
                    last_b_nx = 1'b1;
                    state_nx  = ST_ADDR_WR;
                end
            end
            ST_ADDR_WR: if (cen) begin
                state_nx = ST_ADDR_WAIT;
                cnt_nx   = 7'd0;
            end
            ST_ADDR_WAIT: if (cen) begin
                if (cnt_inc == ADDR_CNT) begin
                    state_nx = ST_DATA_WR;
                    cnt_nx   = 7'd0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            ST_DATA_WR: if (cen) begin
                state_nx = ST_DATA_WAIT;
                cnt_nx   = 7'd0;
            end
            ST_DATA_WAIT: if (cen) begin
                if (cnt_inc == DATA_CNT) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = 7'd0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with it.
    always_comb begin
        strobe_nx = (state_nx == ST_ADDR_WR) || (state_nx == ST_DATA_WR);
        addr_nx   = opl_addr;
        din_nx    = opl_din;
        if (state_nx == ST_ADDR_WR) begin
            addr_nx = 1'b0;
            din_nx  = reg_nx;
        end else if (state_nx == ST_DATA_WR) begin
            addr_nx = 1'b1;
            din_nx  = data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= 7'd0;
            reg_q    <= 8'd0;
            data_q   <= 8'd0;
            last_b   <= 1'b1;
            opl_cs_n <= 1'b1;
            opl_wr_n <= 1'b1;
            opl_addr <= 1'b0;
            opl_din  <= 8'd0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            reg_q    <= reg_nx;
            data_q   <= data_nx;
            last_b   <= last_b_nx;
            opl_cs_n <= !strobe_nx;
            opl_wr_n <= !strobe_nx;
            opl_addr <= addr_nx;
            opl_din  <= din_nx;
        end
    end

endmodule

// File: tb/tb_jtopl_wrseq.sv
// tb/tb_jtopl_wrseq.sv - directed self-checking bench for jtopl_wrseq
module tb_jtopl_wrseq;

    logic       clk, rst_n, cen;
    logic       a_valid, b_valid, a_ready, b_ready;
    logic [7:0] a_reg, a_data, b_reg, b_data, opl_din;
    logic       opl_addr, opl_cs_n, opl_wr_n, busy, last_b;

    logic       s_a_valid, s_b_valid, s_a_ready, s_b_ready;
    logic [7:0] s_a_reg, s_a_data, s_b_reg, s_b_data, s_din;
    logic       s_addr, s_cs_n, s_wr_n, s_busy, s_last_b;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int cen_mode = 0;

    jtopl_wrseq dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .opl_addr(opl_addr), .opl_din(opl_din), .opl_cs_n(opl_cs_n), .opl_wr_n(opl_wr_n),
        .busy(busy), .last_b(last_b)
    );

    jtopl_wrseq #(.ADDR_WAIT(1), .DATA_WAIT(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .a_valid(s_a_valid), .a_reg(s_a_reg), .a_data(s_a_data), .a_ready(s_a_ready),
        .b_valid(s_b_valid), .b_reg(s_b_reg), .b_data(s_b_data), .b_ready(s_b_ready),
        .opl_addr(s_addr), .opl_din(s_din), .opl_cs_n(s_cs_n), .opl_wr_n(s_wr_n),
        .busy(s_busy), .last_b(s_last_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cen_mode: 0 = every cycle, 1 = every 4th cycle, 2 = held low
    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        case (cen_mode)
            1:       cen = (cyc % 4 == 0);
            2:       cen = 1'b0;
            default: cen = 1'b1;
        endcase
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        tick();
        tick();
        tests++;
        if ({busy, opl_cs_n, opl_wr_n, opl_addr, opl_din, last_b} !== {1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1}) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b cs_n=%b wr_n=%b addr=%b din=%h last_b=%b, want 0 1 1 0 00 1",
                     busy, opl_cs_n, opl_wr_n, opl_addr, opl_din, last_b);
        end
        tests++;
        if ({a_ready, b_ready} !== 2'b00) begin
            fails++;
            $display("FAIL reset_ready: got a_ready=%b b_ready=%b, want 0 0", a_ready, b_ready);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        int idx, busy_cnt, nstrobe, data_idx;
        logic [8:0] data_seen;
        logic [9:0] held1;
        logic [10:0] after14;
        a_reg = 8'h20;
        a_data = 8'h01;
        a_valid = 1'b1;
        #1;
        tests++;
        if ({a_ready, b_ready} !== 2'b10) begin
            fails++;
            $display("FAIL single_ready: got a_ready=%b b_ready=%b, want 1 0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        tests++;
        if ({opl_cs_n, opl_wr_n, opl_addr, opl_din, busy, last_b} !== {1'b0, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL single_addr_strobe: got cs_n=%b wr_n=%b addr=%b din=%h busy=%b last_b=%b, want 0 0 0 20 1 0",
                     opl_cs_n, opl_wr_n, opl_addr, opl_din, busy, last_b);
        end
        idx = 0; busy_cnt = 1; nstrobe = 1; data_idx = -1;
        data_seen = 9'h0; held1 = 10'h0; after14 = 11'h0;
        while (busy && idx < 300) begin
            tick();
            idx++;
            if (busy) busy_cnt++;
            if (!opl_cs_n) begin
                nstrobe++;
                data_idx = idx;
                data_seen = {opl_addr, opl_din};
            end
            if (idx == 1) held1 = {opl_cs_n, opl_addr, opl_din};
            if (idx == 14) after14 = {opl_cs_n, opl_wr_n, opl_addr, opl_din};
        end
        tests++;
        if (busy_cnt !== 98) begin
            fails++;
            $display("FAIL single_busy_len: got %0d cycles, want 98", busy_cnt);
        end
        tests++;
        if (nstrobe !== 2 || data_idx !== 13) begin
            fails++;
            $display("FAIL single_strobes: got %0d strobes, data at %0d, want 2 strobes, data at 13", nstrobe, data_idx);
        end
        tests++;
        if (data_seen !== {1'b1, 8'h01}) begin
            fails++;
            $display("FAIL single_data_strobe: got addr/din=%h, want 101", data_seen);
        end
        tests++;
        if (held1 !== {1'b1, 1'b0, 8'h20}) begin
            fails++;
            $display("FAIL single_addr_hold: got cs_n/addr/din=%h, want 220", held1);
        end
        tests++;
        if (after14 !== {1'b1, 1'b1, 1'b1, 8'h01}) begin
            fails++;
            $display("FAIL single_data_hold: got cs_n/wr_n/addr/din=%h, want 701", after14);
        end
    endtask

    task automatic test_round_robin;
        int n;
        bit bad, exp_b;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a_reg = 8'hA0; a_data = 8'h11;
        b_reg = 8'hB0; b_data = 8'h22;
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_b = k[0];
            #1;
            tests++;
            if ({a_ready, b_ready} !== {~exp_b, exp_b}) begin
                fails++;
                $display("FAIL rr_grant%0d: got a_ready=%b b_ready=%b, want %b %b", k, a_ready, b_ready, ~exp_b, exp_b);
            end
            tick();
            tests++;
            if ({last_b, opl_din} !== {exp_b, exp_b ? 8'hB0 : 8'hA0}) begin
                fails++;
                $display("FAIL rr_latch%0d: got last_b=%b din=%h, want %b %h", k, last_b, opl_din, exp_b, exp_b ? 8'hB0 : 8'hA0);
            end
            bad = 1'b0;
            n = 0;
            while (busy && n < 200) begin
                if (a_ready || b_ready) bad = 1'b1;
                tick();
                n++;
            end
            tests++;
            if (bad || n !== 98) begin
                fails++;
                $display("FAIL rr_seq%0d: got ready_during_busy=%b busy_len=%0d, want 0 98", k, bad, n);
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_cen_slow;
        int wr_len, w, n;
        bit bad;
        cen_mode = 1;
        tick();
        a_reg = 8'h31; a_data = 8'h42;
        a_valid = 1'b1;
        #1;
        tests++;
        if (a_ready !== 1'b1) begin
            fails++;
            $display("FAIL slow_ready: got a_ready=%b, want 1", a_ready);
        end
        tick();
        a_valid = 1'b0;
        wr_len = 1;
        bad = (opl_cs_n !== 1'b0);
        while (!cen && wr_len < 10) begin
            tick();
            if (opl_cs_n) bad = 1'b1;
            wr_len++;
        end
        tick();
        tests++;
        if (bad || opl_cs_n !== 1'b1) begin
            fails++;
            $display("FAIL slow_addr_wr: got early_release=%b cs_n_after=%b, want 0 1", bad, opl_cs_n);
        end
        w = 1;
        while (w < 200) begin
            tick();
            if (opl_cs_n) w++;
            else break;
        end
        tests++;
        if (w !== 48 || opl_addr !== 1'b1) begin
            fails++;
            $display("FAIL slow_addr_wait: got %0d cycles addr=%b, want 48 1", w, opl_addr);
        end
        cen_mode = 0;
        wait_idle(200, n);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL slow_timeout: got busy=%b after %0d cycles, want 0", busy, n);
        end
    endtask

    task automatic test_cen_hold;
        int n;
        bit bad;
        cen_mode = 2;
        tick();
        a_reg = 8'h40; a_data = 8'h77;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ({opl_cs_n, opl_wr_n, busy} !== 3'b001) bad = 1'b1;
            tick();
        end
        tests++;
        if (bad || {opl_cs_n, opl_wr_n, opl_din} !== {2'b00, 8'h40}) begin
            fails++;
            $display("FAIL cen_hold: got dropped=%b cs_n=%b wr_n=%b din=%h, want 0 0 0 40", bad, opl_cs_n, opl_wr_n, opl_din);
        end
        cen_mode = 0;
        wait_idle(200, n);
    endtask

    task automatic test_reset_mid;
        int n;
        a_reg = 8'hC0; a_data = 8'h33;
        b_reg = 8'hB1; b_data = 8'h44;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b1;
        n = 0;
        while (!(opl_addr && opl_cs_n) && n < 100) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if ({busy, opl_addr, opl_din} !== {1'b1, 1'b1, 8'h33}) begin
            fails++;
            $display("FAIL mid_precond: got busy=%b addr=%b din=%h, want 1 1 33", busy, opl_addr, opl_din);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, opl_cs_n, opl_wr_n, opl_addr, opl_din, last_b, a_ready, b_ready} !==
            {1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL mid_async_reset: got busy=%b cs_n=%b wr_n=%b addr=%b din=%h last_b=%b rdy=%b%b, want 0 1 1 0 00 1 00",
                     busy, opl_cs_n, opl_wr_n, opl_addr, opl_din, last_b, a_ready, b_ready);
        end
        tick();
        rst_n = 1'b1;
        a_valid = 1'b1;
        #1;
        tests++;
        if ({a_ready, b_ready} !== 2'b10) begin
            fails++;
            $display("FAIL mid_first_grant: got a_ready=%b b_ready=%b, want 1 0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        wait_idle(200, n);
    endtask

    task automatic test_latch;
        int n;
        a_reg = 8'h55; a_data = 8'h5A;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        a_reg = 8'hEE;
        a_data = 8'hFF;
        n = 0;
        while (!(opl_addr && !opl_cs_n) && n < 100) begin
            tick();
            n++;
        end
        tests++;
        if ({opl_cs_n, opl_addr, opl_din} !== {1'b0, 1'b1, 8'h5A}) begin
            fails++;
            $display("FAIL latch_data: got cs_n=%b addr=%b din=%h, want 0 1 5a", opl_cs_n, opl_addr, opl_din);
        end
        wait_idle(200, n);
    endtask

    task automatic test_back_to_back;
        logic [15:0] acc;
        int busy_cnt;
        logic [9:0] c1, c3;
        s_a_reg = 8'h33; s_a_data = 8'h44;
        s_a_valid = 1'b1;
        acc = 16'h0; busy_cnt = 0; c1 = 10'h0; c3 = 10'h0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (s_a_ready) acc[i] = 1'b1;
            if (s_busy) busy_cnt++;
            if (i == 1) c1 = {s_cs_n, s_addr, s_din};
            if (i == 3) c3 = {s_cs_n, s_addr, s_din};
            tick();
        end
        s_a_valid = 1'b0;
        tests++;
        if (acc !== 16'b1000_0100_0010_0001) begin
            fails++;
            $display("FAIL b2b_accepts: got %b, want 1000010000100001", acc);
        end
        tests++;
        if (busy_cnt !== 12) begin
            fails++;
            $display("FAIL b2b_busy: got %0d busy cycles, want 12", busy_cnt);
        end
        tests++;
        if (c1 !== {1'b0, 1'b0, 8'h33} || c3 !== {1'b0, 1'b1, 8'h44}) begin
            fails++;
            $display("FAIL b2b_strobes: got addr-phase %h data-phase %h, want 033 144", c1, c3);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cen = 1'b1;
        a_valid = 1'b0; a_reg = 8'h00; a_data = 8'h00;
        b_valid = 1'b0; b_reg = 8'h00; b_data = 8'h00;
        s_a_valid = 1'b0; s_a_reg = 8'h00; s_a_data = 8'h00;
        s_b_valid = 1'b0; s_b_reg = 8'h00; s_b_data = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_cen_slow();
        test_cen_hold();
        test_reset_mid();
        test_latch();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
